// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the MIPS-31 core: owns PC/IR, sequences fetch/decode/exec/mem/wb.
// Optional performance counters are built when PERF_CNT_EN is defined.
module mc_sequencer #(
  parameter int unsigned          XLEN        = 32,
  parameter logic [XLEN-1:0]      RESET_PC    = 32'h0040_0000,
  parameter int unsigned          MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     ir,
  output logic            rf_we,
  output logic            pc_we,
  output logic            retire,
  output logic [2:0]      state_o,
  output logic            trap,
  output logic [1:0]      trap_cause
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam int unsigned      CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc_q;
  logic [31:0]       ir_q;
  logic              redir_q;
  logic [XLEN-1:0]   tgt_q;
  logic              trap_q;
  logic [1:0]        cause_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              ir_load;
  logic              exec_latch;
  logic              wait_inc;
  logic              trap_set;
  logic [1:0]        cause_n;
  logic              timeout_hit;

  // Exactly the 31 supported encodings; everything else traps as illegal.
  function automatic logic is_legal(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    is_legal = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h08:   is_legal = 1'b1;
        default: is_legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
        6'h04, 6'h05, 6'h0A, 6'h0B, 6'h02, 6'h03:
                 is_legal = 1'b1;
        default: is_legal = 1'b0;
      endcase
    end
  endfunction

  // jr, sw, beq, bne and j produce no register result.
  function automatic logic writes_rf(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    writes_rf = 1'b0;
    if (op == 6'h00) begin
      writes_rf = (instr[5:0] != 6'h08);
    end else begin
      case (op)
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
        6'h23, 6'h03: writes_rf = 1'b1;
        default:      writes_rf = 1'b0;
      endcase
    end
  endfunction

  function automatic logic is_mem_op(input logic [31:0] instr);
    is_mem_op = (instr[31:26] == 6'h23) || (instr[31:26] == 6'h2B);
  endfunction

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);

  always_comb begin
    state_n    = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    retire     = 1'b0;
    ir_load    = 1'b0;
    exec_latch = 1'b0;
    wait_inc   = 1'b0;
    trap_set   = 1'b0;
    cause_n    = 2'b00;
    case (state)
      S_FETCH: begin
        imem_req = !rst;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_n = S_DECODE;
        end else begin
          wait_inc = 1'b1;
          if (timeout_hit) begin
            trap_set = 1'b1;
            cause_n  = CAUSE_TIMEOUT;
            state_n  = S_TRAP;
          end
        end
      end
      S_DECODE: begin
        if (is_legal(ir_q)) begin
          state_n = S_EXEC;
        end else begin
          trap_set = 1'b1;
          cause_n  = CAUSE_ILLEGAL;
          state_n  = S_TRAP;
        end
      end
      S_EXEC: begin
        exec_latch = 1'b1;
        if (br_taken && (br_target[1:0] != 2'b00)) begin
          trap_set = 1'b1;
          cause_n  = CAUSE_ALIGN;
          state_n  = S_TRAP;
        end else if (is_mem_op(ir_q)) begin
          state_n = S_MEM;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (ir_q[31:26] == 6'h2B);
        if (dmem_ready) begin
          state_n = S_WB;
        end else begin
          wait_inc = 1'b1;
          if (timeout_hit) begin
            trap_set = 1'b1;
            cause_n  = CAUSE_TIMEOUT;
            state_n  = S_TRAP;
          end
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        retire  = 1'b1;
        rf_we   = writes_rf(ir_q);
        state_n = S_FETCH;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      redir_q  <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_inc ? wait_cnt + 1'b1 : '0;
      if (ir_load)
        ir_q <= imem_rdata;
      if (exec_latch)
        redir_q <= br_taken;
      if (pc_we)
        pc_q <= redir_q ? tgt_q : pc_q + XLEN'(4);
      if (trap_set) begin
        trap_q  <= 1'b1;
        cause_q <= cause_n;
      end
    end
  end

  // Redirect target is pure data; only its companion flag needs a reset value.
  always_ff @(posedge clk) begin
    if (exec_latch)
      tgt_q <= br_target;
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: hand-computed vectors checked with immediate assertions.
// Define PERF_CNT_EN for both files to also exercise the performance counters.
module tb_mc_sequencer;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        rf_we;
  logic        pc_we;
  logic        retire;
  logic [2:0]  state_o;
  logic        trap;
  logic [1:0]  trap_cause;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  mc_sequencer #(.XLEN(32), .RESET_PC(RPC), .MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .pc         (pc),
    .ir         (ir),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .retire     (retire),
    .state_o    (state_o),
    .trap       (trap),
    .trap_cause (trap_cause)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    br_taken = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Non-memory instruction from FETCH through WB; checks timing, rf_we and next PC.
  task automatic run_nonmem(input string tag, input logic [31:0] instr, input logic exp_rf,
                            input logic tk, input logic [31:0] tgt, input logic [31:0] exp_pc);
    chk({tag, "_fetch_state"}, state_o, 3'd0);
    imem_ready = 1'b1;
    imem_rdata = instr;
    tick();
    imem_ready = 1'b0;
    chk({tag, "_ir"}, ir, instr);
    chk({tag, "_decode_state"}, state_o, 3'd1);
    tick();
    chk({tag, "_exec_state"}, state_o, 3'd2);
    br_taken  = tk;
    br_target = tgt;
    tick();
    br_taken = 1'b0;
    chk({tag, "_wb_state"}, state_o, 3'd4);
    chk({tag, "_retire"}, retire, 1'b1);
    chk({tag, "_pc_we"}, pc_we, 1'b1);
    chk({tag, "_rf_we"}, rf_we, exp_rf);
    tick();
    chk({tag, "_next_pc"}, pc, exp_pc);
    chk({tag, "_retire_low"}, retire, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    tick();
    tick();
    chk("rst_state", state_o, 3'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_ir", ir, 32'h0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_cause", trap_cause, 2'b00);
    chk("rst_imem_req_held", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_strobes", {rf_we, pc_we, retire}, 3'b000);
    rst = 1'b0;
    #1;
    chk("rel_imem_req", imem_req, 1'b1);
    chk("rel_imem_addr", imem_addr, RPC);

    // addu; a stray dmem_ready outside a request must change nothing
    dmem_ready = 1'b1;
    run_nonmem("addu", 32'h0022_1821, 1'b1, 1'b0, 32'h0, 32'h0040_0004);
    chk("stray_ready_no_dmem_req", dmem_req, 1'b0);
    dmem_ready = 1'b0;

    // lw with dmem_ready after three wait cycles
    chk("lw_addr", imem_addr, 32'h0040_0004);
    imem_ready = 1'b1;
    imem_rdata = 32'h8C22_0004;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lw_dmem_req", dmem_req, 1'b1);
      chk("lw_dmem_we", dmem_we, 1'b0);
      chk("lw_mem_state", state_o, 3'd3);
      dmem_ready = (i == 3);
      tick();
    end
    dmem_ready = 1'b0;
    chk("lw_wb_state", state_o, 3'd4);
    chk("lw_retire", retire, 1'b1);
    chk("lw_rf_we", rf_we, 1'b1);
    chk("lw_dmem_req_off", dmem_req, 1'b0);
    tick();
    chk("lw_next_pc", pc, 32'h0040_0008);

    run_nonmem("beq_taken", 32'h1022_0003, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0100);

    // sw with immediate ready: 5 cycles, store strobe, no writeback
    imem_ready = 1'b1;
    imem_rdata = 32'hAC22_0004;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    chk("sw_dmem_req", dmem_req, 1'b1);
    chk("sw_dmem_we", dmem_we, 1'b1);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("sw_retire", retire, 1'b1);
    chk("sw_rf_we", rf_we, 1'b0);
    tick();
    chk("sw_next_pc", pc, 32'h0040_0104);

    run_nonmem("nop", 32'h0000_0000, 1'b1, 1'b0, 32'h0, 32'h0040_0108);
    run_nonmem("jr", 32'h03E0_0008, 1'b0, 1'b1, 32'h0040_0200, 32'h0040_0200);
    run_nonmem("ori", 32'h3422_00FF, 1'b1, 1'b0, 32'h0, 32'h0040_0204);
    run_nonmem("jal_top", 32'h0C00_0000, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    run_nonmem("pc_wrap", 32'h0022_1821, 1'b1, 1'b0, 32'h0, 32'h0000_0000);

    // misaligned redirect
    imem_ready = 1'b1;
    imem_rdata = 32'h1022_0003;
    tick();
    imem_ready = 1'b0;
    tick();
    br_taken = 1'b1;
    br_target = 32'h0040_0102;
    tick();
    br_taken = 1'b0;
    chk("mis_state", state_o, 3'd7);
    chk("mis_trap", trap, 1'b1);
    chk("mis_cause", trap_cause, 2'b10);
    chk("mis_pc", pc, 32'h0000_0000);
    chk("mis_strobes", {imem_req, dmem_req, rf_we, pc_we, retire}, 5'b00000);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("mis_frozen_state", state_o, 3'd7);
    chk("mis_frozen_req", imem_req, 1'b0);

    // illegal opcode 3F
    do_reset();
    chk("ill_restart_pc", imem_addr, RPC);
    imem_ready = 1'b1;
    imem_rdata = 32'hFC00_0000;
    tick();
    chk("ill_decode", state_o, 3'd1);
    tick();
    chk("ill_trap", trap, 1'b1);
    chk("ill_cause", trap_cause, 2'b01);
    tick();
    tick();
    chk("ill_imem_req", imem_req, 1'b0);
    chk("ill_ir_frozen", ir, 32'hFC00_0000);
    chk("ill_pc_frozen", pc, RPC);
    do_reset();
    chk("ill_rst_trap", trap, 1'b0);
    chk("ill_rst_cause", trap_cause, 2'b00);
    chk("ill_rst_ir", ir, 32'h0);
    chk("ill_rst_req", imem_req, 1'b1);

    // illegal R-type funct 05
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0005;
    tick();
    imem_ready = 1'b0;
    tick();
    chk("illr_state", state_o, 3'd7);
    chk("illr_cause", trap_cause, 2'b01);

    // fetch timeout after 16 wait cycles
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("to_imem_req", imem_req, 1'b1);
      tick();
    end
    chk("to_state", state_o, 3'd7);
    chk("to_trap", trap, 1'b1);
    chk("to_cause", trap_cause, 2'b11);
    chk("to_req_dropped", imem_req, 1'b0);

    // reset while waiting in MEM
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h8C22_0004;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("mrst_in_mem", state_o, 3'd3);
    chk("mrst_dmem_req", dmem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk("mrst_dmem_dropped", dmem_req, 1'b0);
    chk("mrst_state", state_o, 3'd0);
    chk("mrst_imem_req_held", imem_req, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst_imem_req_back", imem_req, 1'b1);

`ifdef PERF_CNT_EN
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h0022_1821;
    for (int i = 0; i < 40; i++) tick();
    imem_ready = 1'b0;
    chk("perf_instret", instret_cnt, 32'd10);
    chk("perf_cycle", cycle_cnt, 32'd40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
